// File: rtl/mig_tt_sweeper.sv
// ---------------------------------------------------------------------------------------------
// mig_tt_sweeper
//
// Upstream driver/collector for a small combinational cell (x0..x{N-1} -> y0). On an accepted
// start it walks every input minterm in ascending order, holds each one on x_out for
// SETTLE_CYCLES cycles, samples the cell output on y_in for one more cycle, and assembles the
// complete truth table on tt_out.
//
// Optional feature (macro MIG_SWEEP_CMP_EN): adds expected_tt / mismatch. The final table is
// compared against expected_tt on the transition into DONE and the result is registered.
//
// Parameters
//   N_INPUTS       number of cell inputs (1..6); table width TT_W = 2**N_INPUTS
//   SETTLE_CYCLES  cycles x_out is held before y_in is sampled (0..15)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-high
//   start        in   sweep request, accepted in IDLE or DONE only
//   x_out        out  minterm driven to the cell (bit0 = x0), registered
//   y_in         in   cell output for the current x_out
//   busy         out  high while a sweep is in progress
//   done         out  high from sweep end until the next accepted start
//   tt_out       out  truth table, tt_out[i] = y_in sampled while x_out == i
//   expected_tt  in   reference table (MIG_SWEEP_CMP_EN only), stable while busy
//   mismatch     out  registered tt_out != expected_tt (MIG_SWEEP_CMP_EN only)
// ---------------------------------------------------------------------------------------------
module mig_tt_sweeper #(
   parameter int unsigned N_INPUTS      = 4,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [N_INPUTS-1:0]      x_out,
   input  logic                     y_in,
   output logic                     busy,
   output logic                     done,
   output logic [(1<<N_INPUTS)-1:0] tt_out
`ifdef MIG_SWEEP_CMP_EN
   ,
   input  logic [(1<<N_INPUTS)-1:0] expected_tt,
   output logic                     mismatch
`endif
);

   localparam int unsigned TT_W  = 1 << N_INPUTS;
   // One spare bit so the last-minterm compare can never alias through a wrap.
   localparam int unsigned IDX_W = N_INPUTS + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_W - 1);
   // The down-counter is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES.
   localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StSample,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [TT_W-1:0]  tt_q, tt_d;
`ifdef MIG_SWEEP_CMP_EN
   logic             mismatch_q, mismatch_d;
`endif

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cnt_q      <= '0;
         tt_q       <= '0;
`ifdef MIG_SWEEP_CMP_EN
         mismatch_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         tt_q       <= tt_d;
`ifdef MIG_SWEEP_CMP_EN
         mismatch_q <= mismatch_d;
`endif
      end
   end

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      tt_d       = tt_q;
`ifdef MIG_SWEEP_CMP_EN
      mismatch_d = mismatch_q;
`endif

      case (state_q)
         // IDLE and DONE accept start identically; a restart from DONE discards the old table.
         StIdle, StDone: begin
            if (start) begin
               idx_d = '0;
               cnt_d = SETTLE_INIT;
               tt_d  = '0;
`ifdef MIG_SWEEP_CMP_EN
               mismatch_d = 1'b0;
`endif
               if (SETTLE_CYCLES == 0) begin
                  state_d = StSample;
               end else begin
                  state_d = StSettle;
               end
            end
         end

         StSettle: begin
            if (cnt_q == 4'd0) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         // start is not looked at here: the last SAMPLE cycle must not relaunch a sweep.
         StSample: begin
            tt_d[idx_q[N_INPUTS-1:0]] = y_in;
            if (idx_q == LAST_IDX) begin
               // idx stays at the last minterm so x_out holds TT_W-1 in DONE.
               state_d = StDone;
`ifdef MIG_SWEEP_CMP_EN
               // Compare the table including the bit written this cycle.
               mismatch_d = (tt_d != expected_tt);
`endif
            end else begin
               idx_d = idx_q + IDX_W'(1);
               cnt_d = SETTLE_INIT;
               if (SETTLE_CYCLES == 0) begin
                  state_d = StSample;
               end else begin
                  state_d = StSettle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------------------------------
   // Outputs, all taken straight from registers
   // ------------------------------------------------------------------------------------------
   always_comb begin
      x_out  = idx_q[N_INPUTS-1:0];
      busy   = (state_q == StSettle) || (state_q == StSample);
      done   = (state_q == StDone);
      tt_out = tt_q;
   end

`ifdef MIG_SWEEP_CMP_EN
   assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// ---------------------------------------------------------------------------------------------
// tb_mig_tt_sweeper
//
// Directed bench for mig_tt_sweeper. Three instances with N_INPUTS=4:
//   slot 0: SETTLE_CYCLES=1 (default), slot 1: SETTLE_CYCLES=2, slot 2: SETTLE_CYCLES=0.
// Each slot's cell is modelled in the bench: AND2 (x0 & x1) or XOR4 (^x) selected by ymode.
// With MIG_SWEEP_CMP_EN defined the compare ports are exercised on slot 0 as well.
// ---------------------------------------------------------------------------------------------
module tb_mig_tt_sweeper;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  start;
   logic [2:0]  ymode;
   wire  [2:0]  y_in;
   wire  [2:0]  busy;
   wire  [2:0]  done;
   wire  [11:0] x_all;
   wire  [47:0] tt_all;
`ifdef MIG_SWEEP_CMP_EN
   logic [47:0] exp_all;
   wire  [2:0]  mism;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Cell models: ymode=0 -> AND2 (tt 16'h8888), ymode=1 -> XOR4 (tt 16'h6996).
   for (genvar g = 0; g < 3; g++) begin : g_cell
      assign y_in[g] = ymode[g] ? (^x_all[g*4 +: 4]) : (x_all[g*4] & x_all[g*4+1]);
   end

   mig_tt_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .start(start[0]), .x_out(x_all[3:0]), .y_in(y_in[0]),
      .busy(busy[0]), .done(done[0]), .tt_out(tt_all[15:0])
`ifdef MIG_SWEEP_CMP_EN
      , .expected_tt(exp_all[15:0]), .mismatch(mism[0])
`endif
   );

   mig_tt_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(2)) u_dut_s2 (
      .clk(clk), .rst(rst), .start(start[1]), .x_out(x_all[7:4]), .y_in(y_in[1]),
      .busy(busy[1]), .done(done[1]), .tt_out(tt_all[31:16])
`ifdef MIG_SWEEP_CMP_EN
      , .expected_tt(exp_all[31:16]), .mismatch(mism[1])
`endif
   );

   mig_tt_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(0)) u_dut_s0 (
      .clk(clk), .rst(rst), .start(start[2]), .x_out(x_all[11:8]), .y_in(y_in[2]),
      .busy(busy[2]), .done(done[2]), .tt_out(tt_all[47:32])
`ifdef MIG_SWEEP_CMP_EN
      , .expected_tt(exp_all[47:32]), .mismatch(mism[2])
`endif
   );

   function automatic int settle_of(input int w);
      return (w == 0) ? 1 : ((w == 1) ? 2 : 0);
   endfunction

   // Called at posedge+1; returns at posedge+1 just after start was sampled.
   task automatic pulse_start(input int w);
      start[w] = 1'b1;
      @(posedge clk);
      #1;
      start[w] = 1'b0;
   endtask

   // Steps cycle by cycle from cycle count cyc0 until done, bounded. Counts cycles in which
   // x_out is not the minterm due at that point or busy is low before done.
   task automatic wait_done(input int w, input int cyc0, output int cyc, output int xerr);
      int s;
      s    = settle_of(w);
      cyc  = cyc0;
      xerr = 0;
      if (x_all[w*4 +: 4] !== 4'(cyc0 / (s + 1)) || busy[w] !== 1'b1) xerr++;
      while (cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done[w] === 1'b1) break;
         if (busy[w] !== 1'b1 || x_all[w*4 +: 4] !== 4'(cyc / (s + 1))) xerr++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b0;
      start = '0;
      ymode = '0;
`ifdef MIG_SWEEP_CMP_EN
      exp_all = '0;
`endif
      #1 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 3'b000) begin
         failures++; $display("FAIL rst_busy: got %b expected 000", busy);
      end
      checks++;
      if (done !== 3'b000) begin
         failures++; $display("FAIL rst_done: got %b expected 000", done);
      end
      checks++;
      if (x_all !== 12'h000) begin
         failures++; $display("FAIL rst_x_out: got %h expected 000", x_all);
      end
      checks++;
      if (tt_all !== 48'h0) begin
         failures++; $display("FAIL rst_tt_out: got %h expected 0", tt_all);
      end
`ifdef MIG_SWEEP_CMP_EN
      checks++;
      if (mism !== 3'b000) begin
         failures++; $display("FAIL rst_mismatch: got %b expected 000", mism);
      end
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 3'b000 || done !== 3'b000) begin
         failures++; $display("FAIL idle_after_rst: got busy=%b done=%b expected 000/000",
                              busy, done);
      end
   endtask

   task automatic test_and2();
      int cyc, xerr;
      ymode[0] = 1'b0;
      pulse_start(0);
      checks++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
         failures++; $display("FAIL and2_busy_rise: got busy=%b done=%b expected 1/0",
                              busy[0], done[0]);
      end
      wait_done(0, 0, cyc, xerr);
      checks++;
      if (cyc !== 32) begin
         failures++; $display("FAIL and2_latency: got %0d cycles expected 32", cyc);
      end
      checks++;
      if (busy[0] !== 1'b0) begin
         failures++; $display("FAIL and2_busy_fall: got %b expected 0", busy[0]);
      end
      checks++;
      if (xerr !== 0) begin
         failures++; $display("FAIL and2_x_seq: got %0d bad cycles expected 0", xerr);
      end
      checks++;
      if (tt_all[15:0] !== 16'h8888) begin
         failures++; $display("FAIL and2_tt: got %h expected 8888", tt_all[15:0]);
      end
      checks++;
      if (x_all[3:0] !== 4'hf) begin
         failures++; $display("FAIL and2_x_hold: got %h expected f", x_all[3:0]);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done[0] !== 1'b1 || tt_all[15:0] !== 16'h8888) begin
         failures++; $display("FAIL and2_done_hold: got done=%b tt=%h expected 1/8888",
                              done[0], tt_all[15:0]);
      end
   endtask

   // Start from DONE relaunches with a cleared table; the cell is switched to XOR4.
   task automatic test_restart_xor();
      int cyc, xerr;
      ymode[0] = 1'b1;
      pulse_start(0);
      checks++;
      if (tt_all[15:0] !== 16'h0000 || done[0] !== 1'b0 || busy[0] !== 1'b1) begin
         failures++; $display("FAIL restart_clear: got tt=%h done=%b busy=%b expected 0000/0/1",
                              tt_all[15:0], done[0], busy[0]);
      end
      wait_done(0, 0, cyc, xerr);
      checks++;
      if (cyc !== 32 || xerr !== 0) begin
         failures++; $display("FAIL xor_timing: got cyc=%0d xerr=%0d expected 32/0", cyc, xerr);
      end
      checks++;
      if (tt_all[15:0] !== 16'h6996) begin
         failures++; $display("FAIL xor_tt: got %h expected 6996", tt_all[15:0]);
      end
   endtask

   task automatic test_start_ignored();
      int cyc, xerr;
      ymode[0] = 1'b0;
      pulse_start(0);
      repeat (10) @(posedge clk);
      #1;
      // Minterms 0..4 sampled so far: only bit 3 of AND2 is set.
      checks++;
      if (x_all[3:0] !== 4'd5 || tt_all[15:0] !== 16'h0008) begin
         failures++; $display("FAIL partial_tt: got x=%h tt=%h expected 5/0008",
                              x_all[3:0], tt_all[15:0]);
      end
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      wait_done(0, 11, cyc, xerr);
      checks++;
      if (cyc !== 32 || xerr !== 0) begin
         failures++; $display("FAIL start_ignored: got cyc=%0d xerr=%0d expected 32/0",
                              cyc, xerr);
      end
      checks++;
      if (tt_all[15:0] !== 16'h8888) begin
         failures++; $display("FAIL start_ignored_tt: got %h expected 8888", tt_all[15:0]);
      end
   endtask

   task automatic test_settle2();
      int cyc, xerr;
      ymode[1] = 1'b1;
      pulse_start(1);
      wait_done(1, 0, cyc, xerr);
      checks++;
      if (cyc !== 48) begin
         failures++; $display("FAIL settle2_latency: got %0d cycles expected 48", cyc);
      end
      checks++;
      if (xerr !== 0 || busy[1] !== 1'b0) begin
         failures++; $display("FAIL settle2_x_seq: got xerr=%0d busy=%b expected 0/0",
                              xerr, busy[1]);
      end
      checks++;
      if (tt_all[31:16] !== 16'h6996) begin
         failures++; $display("FAIL settle2_tt: got %h expected 6996", tt_all[31:16]);
      end
   endtask

   task automatic test_settle0();
      int cyc, xerr;
      ymode[2] = 1'b0;
      pulse_start(2);
      wait_done(2, 0, cyc, xerr);
      checks++;
      if (cyc !== 16) begin
         failures++; $display("FAIL settle0_latency: got %0d cycles expected 16", cyc);
      end
      checks++;
      if (xerr !== 0 || busy[2] !== 1'b0) begin
         failures++; $display("FAIL settle0_x_seq: got xerr=%0d busy=%b expected 0/0",
                              xerr, busy[2]);
      end
      checks++;
      if (tt_all[47:32] !== 16'h8888) begin
         failures++; $display("FAIL settle0_tt: got %h expected 8888", tt_all[47:32]);
      end
   endtask

   task automatic test_reset_mid();
      ymode[0] = 1'b0;
      pulse_start(0);
      repeat (18) @(posedge clk);
      #1;
      // idx=9: minterms 0..8 sampled, AND2 bits 3 and 7 set.
      checks++;
      if (x_all[3:0] !== 4'd9 || tt_all[15:0] !== 16'h0088) begin
         failures++; $display("FAIL pre_rst_state: got x=%h tt=%h expected 9/0088",
                              x_all[3:0], tt_all[15:0]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || x_all[3:0] !== 4'h0 ||
          tt_all[15:0] !== 16'h0000) begin
         failures++; $display("FAIL mid_rst: got busy=%b done=%b x=%h tt=%h expected 0/0/0/0000",
                              busy[0], done[0], x_all[3:0], tt_all[15:0]);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || tt_all[15:0] !== 16'h0000) begin
         failures++; $display("FAIL post_rst_idle: got busy=%b done=%b tt=%h expected 0/0/0000",
                              busy[0], done[0], tt_all[15:0]);
      end
   endtask

`ifdef MIG_SWEEP_CMP_EN
   task automatic test_compare();
      int cyc, xerr;
      ymode[0]      = 1'b0;
      exp_all[15:0] = 16'h8888;
      pulse_start(0);
      wait_done(0, 0, cyc, xerr);
      checks++;
      if (done[0] !== 1'b1 || mism[0] !== 1'b0) begin
         failures++; $display("FAIL cmp_match: got done=%b mismatch=%b expected 1/0",
                              done[0], mism[0]);
      end
      exp_all[15:0] = 16'h8889;
      pulse_start(0);
      wait_done(0, 0, cyc, xerr);
      checks++;
      if (done[0] !== 1'b1 || mism[0] !== 1'b1) begin
         failures++; $display("FAIL cmp_mismatch: got done=%b mismatch=%b expected 1/1",
                              done[0], mism[0]);
      end
      pulse_start(0);
      checks++;
      if (mism[0] !== 1'b0) begin
         failures++; $display("FAIL cmp_clear: got %b expected 0", mism[0]);
      end
      wait_done(0, 0, cyc, xerr);
   endtask
`endif

   initial begin
      test_reset();
      test_and2();
      test_restart_xor();
      test_start_ignored();
      test_settle2();
      test_settle0();
      test_reset_mid();
`ifdef MIG_SWEEP_CMP_EN
      test_compare();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
